// File: rtl/decode_stage.sv
// decode_stage: IF/ID boundary of the five-stage MIPS pipeline. Decodes one instruction
// per cycle into a registered ID/EX bundle and owns the 32x32 general-purpose register file.
module decode_stage (
    input  logic        CLK,
    input  logic        RST,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc_plus4,
    input  logic        ex_ready,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        id_valid,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_rs_data,
    output logic [31:0] id_rt_data,
    output logic [31:0] id_imm,
    output logic [4:0]  id_shamt,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_dest,
    output logic [3:0]  id_alu_op,
    output logic        id_alu_src,
    output logic        id_reg_write,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic        id_mem_to_reg,
    output logic        id_link,
    output logic        id_branch_eq,
    output logic        id_branch_ne,
    output logic        id_jump,
    output logic        id_jump_reg,
    output logic [31:0] id_branch_target,
    output logic [31:0] id_jump_target,
    output logic        id_illegal
);

    // Handshake: a word moves across a boundary on a rising edge where valid && ready;
    // while valid && !ready the producer keeps its word (and valid) unchanged.

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        link;
        logic        branch_eq;
        logic        branch_ne;
        logic        jump;
        logic        jump_reg;
        logic [31:0] branch_target;
        logic [31:0] jump_target;
        logic        illegal;
    } id_bundle_t;

    logic [5:0]  instr_op;
    logic [5:0]  instr_funct;
    logic [4:0]  instr_rs;
    logic [4:0]  instr_rt;
    logic [4:0]  instr_rd;
    logic [4:0]  instr_shamt;
    logic [15:0] instr_imm;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;

    assign instr_op    = if_instr[31:26];
    assign instr_rs    = if_instr[25:21];
    assign instr_rt    = if_instr[20:16];
    assign instr_rd    = if_instr[15:11];
    assign instr_shamt = if_instr[10:6];
    assign instr_funct = if_instr[5:0];
    assign instr_imm   = if_instr[15:0];
    assign imm_sext    = {{16{instr_imm[15]}}, instr_imm};
    assign imm_zext    = {16'h0000, instr_imm};

    id_bundle_t  id_q, id_d, dec;
    logic        valid_q, valid_d;
    logic [31:0] rs_data_q, rs_data_d;
    logic [31:0] rt_data_q, rt_data_d;
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];
    logic        accept;
    logic        legal;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;

    // $0 is hard-wired; a same-cycle write to the index being read is forwarded.
    function automatic logic [31:0] rf_read(input logic [4:0] idx, input logic [31:0] stored,
                                            input logic w_en, input logic [4:0] w_addr,
                                            input logic [31:0] w_data);
        if (idx == 5'd0) begin
            return 32'h0000_0000;
        end else if (w_en && (w_addr == idx)) begin
            return w_data;
        end
        return stored;
    endfunction

    always_comb begin
        dec               = '0;
        legal             = 1'b1;
        dec.pc_plus4      = if_pc_plus4;
        dec.rs            = instr_rs;
        dec.rt            = instr_rt;
        dec.shamt         = instr_shamt;
        dec.dest          = instr_rt;
        dec.imm           = imm_sext;
        dec.branch_target = if_pc_plus4 + {imm_sext[29:0], 2'b00};
        dec.jump_target   = {if_pc_plus4[31:28], if_instr[25:0], 2'b00};
        case (instr_op)
            OP_RTYPE: begin
                dec.dest      = instr_rd;
                dec.reg_write = 1'b1;
                case (instr_funct)
                    F_ADD, F_ADDU: dec.alu_op = ALU_ADD;
                    F_SUB, F_SUBU: dec.alu_op = ALU_SUB;
                    F_AND:         dec.alu_op = ALU_AND;
                    F_OR:          dec.alu_op = ALU_OR;
                    F_XOR:         dec.alu_op = ALU_XOR;
                    F_NOR:         dec.alu_op = ALU_NOR;
                    F_SLT:         dec.alu_op = ALU_SLT;
                    F_SLTU:        dec.alu_op = ALU_SLTU;
                    F_SLL:         dec.alu_op = ALU_SLL;
                    F_SRL:         dec.alu_op = ALU_SRL;
                    F_SRA:         dec.alu_op = ALU_SRA;
                    F_JR: begin
                        dec.reg_write = 1'b0;
                        dec.jump_reg  = 1'b1;
                    end
                    default:       legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                if (instr_op == OP_SLTI) begin
                    dec.alu_op = ALU_SLT;
                end else if (instr_op == OP_SLTIU) begin
                    dec.alu_op = ALU_SLTU;
                end
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm       = imm_zext;
                if (instr_op == OP_ANDI) begin
                    dec.alu_op = ALU_AND;
                end else if (instr_op == OP_ORI) begin
                    dec.alu_op = ALU_OR;
                end else begin
                    dec.alu_op = ALU_XOR;
                end
            end
            OP_LUI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm       = {instr_imm, 16'h0000};
                dec.alu_op    = ALU_LUI;
            end
            OP_LW: begin
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            OP_BEQ: begin
                dec.alu_op    = ALU_SUB;
                dec.branch_eq = 1'b1;
            end
            OP_BNE: begin
                dec.alu_op    = ALU_SUB;
                dec.branch_ne = 1'b1;
            end
            OP_J: begin
                dec.dest = 5'd0;
                dec.jump = 1'b1;
            end
            OP_JAL: begin
                dec.dest      = 5'd31;
                dec.jump      = 1'b1;
                dec.link      = 1'b1;
                dec.reg_write = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        // An unknown encoding must not disturb architectural state downstream.
        if (!legal) begin
            dec.alu_op     = ALU_ADD;
            dec.alu_src    = 1'b0;
            dec.reg_write  = 1'b0;
            dec.mem_read   = 1'b0;
            dec.mem_write  = 1'b0;
            dec.mem_to_reg = 1'b0;
            dec.link       = 1'b0;
            dec.branch_eq  = 1'b0;
            dec.branch_ne  = 1'b0;
            dec.jump       = 1'b0;
            dec.jump_reg   = 1'b0;
            dec.dest       = 5'd0;
            dec.illegal    = 1'b1;
        end
        if (dec.dest == 5'd0) begin
            dec.reg_write = 1'b0;
        end
    end

    assign if_ready = !valid_q || ex_ready;

    always_comb begin
        rf_d = rf_q;
        if (wb_en && (wb_addr != 5'd0)) begin
            rf_d[wb_addr] = wb_data;
        end
    end

    // Operand data is re-read every cycle so a held instruction picks up late writebacks.
    always_comb begin
        accept  = if_valid && if_ready && !flush;
        valid_d = valid_q;
        id_d    = id_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            id_d    = dec;
        end else if (ex_ready) begin
            valid_d = 1'b0;
        end
        rs_idx    = accept ? instr_rs : id_q.rs;
        rt_idx    = accept ? instr_rt : id_q.rt;
        rs_data_d = rf_read(rs_idx, rf_q[rs_idx], wb_en, wb_addr, wb_data);
        rt_data_d = rf_read(rt_idx, rf_q[rt_idx], wb_en, wb_addr, wb_data);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q   <= 1'b0;
            id_q      <= '0;
            rs_data_q <= 32'h0000_0000;
            rt_data_q <= 32'h0000_0000;
            rf_q      <= '{default: 32'h0000_0000};
        end else begin
            valid_q   <= valid_d;
            id_q      <= id_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            rf_q      <= rf_d;
        end
    end

    assign id_valid         = valid_q;
    assign id_pc_plus4      = id_q.pc_plus4;
    assign id_rs_data       = rs_data_q;
    assign id_rt_data       = rt_data_q;
    assign id_imm           = id_q.imm;
    assign id_shamt         = id_q.shamt;
    assign id_rs            = id_q.rs;
    assign id_rt            = id_q.rt;
    assign id_dest          = id_q.dest;
    assign id_alu_op        = id_q.alu_op;
    assign id_alu_src       = id_q.alu_src;
    assign id_reg_write     = id_q.reg_write;
    assign id_mem_read      = id_q.mem_read;
    assign id_mem_write     = id_q.mem_write;
    assign id_mem_to_reg    = id_q.mem_to_reg;
    assign id_link          = id_q.link;
    assign id_branch_eq     = id_q.branch_eq;
    assign id_branch_ne     = id_q.branch_ne;
    assign id_jump          = id_q.jump;
    assign id_jump_reg      = id_q.jump_reg;
    assign id_branch_target = id_q.branch_target;
    assign id_jump_target   = id_q.jump_target;
    assign id_illegal       = id_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table of decoded instructions streamed through decode_stage with a
// scoreboard, plus hand-written bypass, stall, flush and reset sequences.
module tb_decode_stage;

    localparam int W = 256;

    logic        CLK = 1'b0;
    logic        RST;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;
    logic        ex_ready;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        id_valid;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [4:0]  id_shamt;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_dest;
    logic [3:0]  id_alu_op;
    logic        id_alu_src;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        id_mem_to_reg;
    logic        id_link;
    logic        id_branch_eq;
    logic        id_branch_ne;
    logic        id_jump;
    logic        id_jump_reg;
    logic [31:0] id_branch_target;
    logic [31:0] id_jump_target;
    logic        id_illegal;

    decode_stage dut (
        .CLK(CLK), .RST(RST),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc_plus4(if_pc_plus4),
        .ex_ready(ex_ready), .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .id_valid(id_valid), .id_pc_plus4(id_pc_plus4),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .id_link(id_link), .id_branch_eq(id_branch_eq), .id_branch_ne(id_branch_ne),
        .id_jump(id_jump), .id_jump_reg(id_jump_reg),
        .id_branch_target(id_branch_target), .id_jump_target(id_jump_target),
        .id_illegal(id_illegal)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    // ctrl bit order: {alu_src, reg_write, mem_read, mem_write, mem_to_reg, link,
    //                  branch_eq, branch_ne, jump, jump_reg}
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [3:0]  alu_op;
        logic [9:0]  ctrl;
        logic        ill;
        logic [4:0]  dest;
        logic [31:0] imm;
    } vec_t;

    vec_t        vecs[$];
    logic [W-1:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] pc_next = 32'hA000_0000;
    logic [W-1:0] mon_got;
    logic [W-1:0] mon_exp;

    function automatic logic [W-1:0] pack(input logic [31:0] pc, input logic [31:0] rs_d,
                                          input logic [31:0] rt_d, input logic [31:0] imm,
                                          input logic [4:0] shamt, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] dest,
                                          input logic [3:0] alu_op, input logic [9:0] ctrl,
                                          input logic ill, input logic [31:0] bt,
                                          input logic [31:0] jt);
        return {29'd0, pc, rs_d, rt_d, imm, shamt, rs, rt, dest, alu_op, ctrl, ill, bt, jt};
    endfunction

    function automatic logic [W-1:0] obs();
        return pack(id_pc_plus4, id_rs_data, id_rt_data, id_imm, id_shamt, id_rs, id_rt, id_dest,
                    id_alu_op, {id_alu_src, id_reg_write, id_mem_read, id_mem_write,
                    id_mem_to_reg, id_link, id_branch_eq, id_branch_ne, id_jump, id_jump_reg},
                    id_illegal, id_branch_target, id_jump_target);
    endfunction

    function automatic vec_t mkvec(input logic [31:0] instr, input logic [31:0] pc,
                                   input logic [3:0] alu_op, input logic [9:0] ctrl,
                                   input logic ill, input logic [4:0] dest,
                                   input logic [31:0] imm);
        vec_t v;
        v.instr = instr; v.pc = pc; v.alu_op = alu_op; v.ctrl = ctrl;
        v.ill = ill; v.dest = dest; v.imm = imm;
        return v;
    endfunction

    // Targets follow the architectural definitions: pc+4 + sext(imm)*4, and pc[31:28]|index*4.
    function automatic logic [W-1:0] exp_of(input vec_t v, input logic [31:0] rs_d,
                                            input logic [31:0] rt_d);
        logic [31:0] bt;
        logic [31:0] jt;
        bt = v.pc + {{14{v.instr[15]}}, v.instr[15:0], 2'b00};
        jt = {v.pc[31:28], v.instr[25:0], 2'b00};
        return pack(v.pc, rs_d, rt_d, v.imm, v.instr[10:6], v.instr[25:21], v.instr[20:16],
                    v.dest, v.alu_op, v.ctrl, v.ill, bt, jt);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        if_valid    = 1'b1;
        if_instr    = instr;
        if_pc_plus4 = pc;
    endtask

    task automatic add_vec(input logic [31:0] instr, input logic [3:0] alu_op,
                           input logic [9:0] ctrl, input logic ill, input logic [4:0] dest,
                           input logic [31:0] imm);
        vecs.push_back(mkvec(instr, pc_next, alu_op, ctrl, ill, dest, imm));
        pc_next = pc_next + 32'd4;
    endtask

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge CLK) begin
        if (RST === 1'b0 && id_valid === 1'b1 && ex_ready === 1'b1) begin
            mon_got = obs();
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got=%0h", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL transfer got=%0h exp=%0h", mon_got, mon_exp);
                end
            end
        end
    end

    // ---------------- test ----------------
    initial begin
        vec_t v;
        RST = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc_plus4 = '0; ex_ready = 1'b1;
        flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;

        add_vec(32'h20010005, 4'd0,  10'b1100000000, 1'b0, 5'd1,  32'h00000005); // addi $1,$0,5
        add_vec(32'h00000000, 4'd8,  10'b0000000000, 1'b0, 5'd0,  32'h00000000); // nop
        add_vec(32'h00221820, 4'd0,  10'b0100000000, 1'b0, 5'd3,  32'h00001820); // add
        add_vec(32'h00A62022, 4'd1,  10'b0100000000, 1'b0, 5'd4,  32'h00002022); // sub
        add_vec(32'h01093824, 4'd2,  10'b0100000000, 1'b0, 5'd7,  32'h00003824); // and
        add_vec(32'h01093825, 4'd3,  10'b0100000000, 1'b0, 5'd7,  32'h00003825); // or
        add_vec(32'h01093826, 4'd4,  10'b0100000000, 1'b0, 5'd7,  32'h00003826); // xor
        add_vec(32'h01093827, 4'd5,  10'b0100000000, 1'b0, 5'd7,  32'h00003827); // nor
        add_vec(32'h0109382A, 4'd6,  10'b0100000000, 1'b0, 5'd7,  32'h0000382A); // slt
        add_vec(32'h0109382B, 4'd7,  10'b0100000000, 1'b0, 5'd7,  32'h0000382B); // sltu
        add_vec(32'h01093821, 4'd0,  10'b0100000000, 1'b0, 5'd7,  32'h00003821); // addu
        add_vec(32'h01093823, 4'd1,  10'b0100000000, 1'b0, 5'd7,  32'h00003823); // subu
        add_vec(32'h000B5100, 4'd8,  10'b0100000000, 1'b0, 5'd10, 32'h00005100); // sll 4
        add_vec(32'h000B57C2, 4'd9,  10'b0100000000, 1'b0, 5'd10, 32'h000057C2); // srl 31
        add_vec(32'h000B5043, 4'd10, 10'b0100000000, 1'b0, 5'd10, 32'h00005043); // sra 1
        add_vec(32'h03E00008, 4'd0,  10'b0000000001, 1'b0, 5'd0,  32'h00000008); // jr $31
        add_vec(32'h0000003F, 4'd0,  10'b0000000000, 1'b1, 5'd0,  32'h0000003F); // bad funct
        add_vec(32'h34C58000, 4'd3,  10'b1100000000, 1'b0, 5'd5,  32'h00008000); // ori
        add_vec(32'h30C5FFFF, 4'd2,  10'b1100000000, 1'b0, 5'd5,  32'h0000FFFF); // andi
        add_vec(32'h38C50001, 4'd4,  10'b1100000000, 1'b0, 5'd5,  32'h00000001); // xori
        add_vec(32'h28C5FFFE, 4'd6,  10'b1100000000, 1'b0, 5'd5,  32'hFFFFFFFE); // slti
        add_vec(32'h2CC58001, 4'd7,  10'b1100000000, 1'b0, 5'd5,  32'hFFFF8001); // sltiu
        add_vec(32'h24C57FFF, 4'd0,  10'b1100000000, 1'b0, 5'd5,  32'h00007FFF); // addiu
        add_vec(32'h3C09ABCD, 4'd11, 10'b1100000000, 1'b0, 5'd9,  32'hABCD0000); // lui
        add_vec(32'h8CA40008, 4'd0,  10'b1110100000, 1'b0, 5'd4,  32'h00000008); // lw
        add_vec(32'hACA4FFFC, 4'd0,  10'b1001000000, 1'b0, 5'd4,  32'hFFFFFFFC); // sw
        add_vec(32'h1022FFFF, 4'd1,  10'b0000001000, 1'b0, 5'd2,  32'hFFFFFFFF); // beq
        add_vec(32'h14220010, 4'd1,  10'b0000000100, 1'b0, 5'd2,  32'h00000010); // bne
        add_vec(32'h08100000, 4'd0,  10'b0000000010, 1'b0, 5'd0,  32'h00000000); // j
        add_vec(32'h0C000010, 4'd0,  10'b0100010010, 1'b0, 5'd31, 32'h00000010); // jal
        add_vec(32'hFC221234, 4'd0,  10'b0000000000, 1'b1, 5'd0,  32'h00001234); // op 3F
        add_vec(32'h40000000, 4'd0,  10'b0000000000, 1'b1, 5'd0,  32'h00000000); // op 10
        add_vec(32'h20000007, 4'd0,  10'b1000000000, 1'b0, 5'd0,  32'h00000007); // addi $0

        repeat (3) step();
        check("reset_valid", id_valid, 0);
        check("reset_outputs", obs(), 0);
        check("reset_if_ready", if_ready, 1);
        RST = 1'b0;
        step();

        // Back-to-back stream at full throughput; register file is all zero here.
        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].instr, vecs[i].pc);
            exp_q.push_back(exp_of(vecs[i], 32'h0, 32'h0));
            step();
        end
        if_valid = 1'b0;
        repeat (2) step();
        check("table_drained", exp_q.size(), 0);

        // Writeback coincident with accept is seen through the bypass.
        send(32'h00421820, 32'h0000_2004);
        wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'hDEADBEEF;
        exp_q.push_back(exp_of(mkvec(32'h00421820, 32'h0000_2004, 4'd0, 10'b0100000000, 1'b0,
                                     5'd3, 32'h00001820), 32'hDEADBEEF, 32'hDEADBEEF));
        step();
        wb_en = 1'b0;
        send(32'h00403020, 32'h0000_2008);
        exp_q.push_back(exp_of(mkvec(32'h00403020, 32'h0000_2008, 4'd0, 10'b0100000000, 1'b0,
                                     5'd6, 32'h00003020), 32'hDEADBEEF, 32'h0));
        step();

        // A write to $0 is neither stored nor forwarded.
        send(32'h00000820, 32'h0000_3004);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
        v = mkvec(32'h00000820, 32'h0000_3004, 4'd0, 10'b0100000000, 1'b0, 5'd1, 32'h00000820);
        exp_q.push_back(exp_of(v, 32'h0, 32'h0));
        step();
        wb_en = 1'b0;
        exp_q.push_back(exp_of(v, 32'h0, 32'h0));
        step();
        if_valid = 1'b0;
        step();

        // beq with imm 0xFFFF at pc+4 = 0x100 targets 0xFC.
        send(32'h1022FFFF, 32'h0000_0100);
        exp_q.push_back(exp_of(mkvec(32'h1022FFFF, 32'h0000_0100, 4'd1, 10'b0000001000, 1'b0,
                                     5'd2, 32'hFFFFFFFF), 32'h0, 32'hDEADBEEF));
        step();
        if_valid = 1'b0;
        check("beq_target", id_branch_target, 32'h0000_00FC);
        check("beq_flags", {id_branch_eq, id_reg_write}, 2'b10);
        step();

        // lw held for three cycles while $5 is written; only rs_data may change.
        v = mkvec(32'h8CA40008, 32'h0000_4004, 4'd0, 10'b1110100000, 1'b0, 5'd4, 32'h00000008);
        send(v.instr, v.pc);
        exp_q.push_back(exp_of(v, 32'h40, 32'h0));
        step();
        if_valid = 1'b0; ex_ready = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h40;
        #1;
        check("lw_accept", obs(), exp_of(v, 32'h0, 32'h0));
        check("lw_hold_if_ready", if_ready, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            wb_en = 1'b0;
            check("lw_hold_fields", obs(), exp_of(v, 32'h40, 32'h0));
            check("lw_hold_valid", {id_valid, if_ready}, 2'b10);
        end
        ex_ready = 1'b1;
        step();
        check("lw_released", id_valid, 0);

        // Flush during a hold drops both the held and the incoming instruction.
        send(32'h34C58000, 32'h0000_5004);
        step();
        ex_ready = 1'b0;
        send(32'h00221820, 32'h0000_5008);
        flush = 1'b1;
        step();
        flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
        check("flush_hold_valid", id_valid, 0);
        repeat (2) step();

        // Flush with no hold drops the incoming instruction.
        send(32'h00221820, 32'h0000_6004);
        flush = 1'b1;
        step();
        flush = 1'b0; if_valid = 1'b0;
        check("flush_idle_valid", id_valid, 0);
        step();

        // Reset in mid-stall discards the held word and clears the register file.
        send(32'h00421820, 32'h0000_7004);
        step();
        if_valid = 1'b0; ex_ready = 1'b0; RST = 1'b1;
        step();
        check("rst_stall_outputs", obs(), 0);
        check("rst_stall_valid", id_valid, 0);
        RST = 1'b0; ex_ready = 1'b1;
        send(32'h00421820, 32'h0000_7008);
        exp_q.push_back(exp_of(mkvec(32'h00421820, 32'h0000_7008, 4'd0, 10'b0100000000, 1'b0,
                                     5'd3, 32'h00001820), 32'h0, 32'h0));
        step();
        if_valid = 1'b0;
        repeat (2) step();

        check("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Second stage of the five-stage MIPS pipeline, directly downstream of fetch. It owns the IF/ID boundary and the 32×32 general-purpose register file. Each accepted instruction is decoded into operands, immediate, destination and control bits, and presented on a registered ID/EX output with a valid/ready handshake. Branch and jump targets are computed here for the PC-select path back into fetch.

## Interface
- No parameters; widths are fixed (32-bit datapath, 5-bit register indices).
- `CLK` in 1: pipeline clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `if_valid` in 1: fetch presents an instruction.
- `if_ready` out 1: decode accepts this cycle; equals `!id_valid || ex_ready`.
- `if_instr` in 32: instruction word.
- `if_pc_plus4` in 32: address of the instruction + 4.
- `ex_ready` in 1: execute accepts the current output.
- `flush` in 1: squash the held and the incoming instruction (taken branch/jump).
- `wb_en`, `wb_addr`, `wb_data` in 1/5/32: register-file write port from writeback.
- `id_valid` out 1: outputs below are meaningful.
- `id_pc_plus4` out 32.
- `id_rs_data`, `id_rt_data` out 32.
- `id_imm` out 32: extended immediate.
- `id_shamt` out 5.
- `id_rs`, `id_rt`, `id_dest` out 5.
- `id_alu_op` out 4: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI.
- `id_alu_src` out 1: operand B is `id_imm` rather than `id_rt_data`.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`, `id_link` out 1.
- `id_branch_eq`, `id_branch_ne`, `id_jump`, `id_jump_reg` out 1.
- `id_branch_target`, `id_jump_target` out 32.
- `id_illegal` out 1.

## Operation
- Accept when `if_valid && if_ready && !flush`. All `id_*` registers load from the decode of `if_instr`, and `id_valid` is set to 1.
- No accept and `ex_ready=1`: `id_valid` clears to 0.
- `id_valid && !ex_ready`: hold. All fields are held except `id_rs_data`/`id_rt_data`, which are re-read every cycle from the held `id_rs`/`id_rt` so that late writebacks are captured.
- `flush`: `id_valid` becomes 0 and any incoming instruction is dropped.
- Register file:
  - Write on `wb_en && wb_addr!=0` at the clock edge.
  - `$0` always reads 0.
  - Write-through bypass: a read of the index being written in the same cycle returns `wb_data`.
- Immediate extension:
  - Sign-extend for addi, addiu, slti, sltiu, lw, sw, beq, bne.
  - Zero-extend for andi, ori, xori.
  - lui yields `{imm,16'h0}` with alu_op LUI.
- R-type (op 0), by funct:
  - 20/21 ADD, 22/23 SUB, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU.
  - 00 SLL, 02 SRL, 03 SRA, each using `id_shamt`.
  - 08 jr: `id_jump_reg=1`, no register write.
  - Destination is rd.
- I-type, by op:
  - 08/09 ADD, 0A SLT, 0B SLTU, 0C AND, 0D OR, 0E XOR, 0F LUI.
  - 23 lw: ADD, `mem_read`, `mem_to_reg`.
  - 2B sw: ADD, `mem_write`, no register write.
  - 04 beq, 05 bne: SUB, no register write.
  - Destination is rt; `alu_src=1` except for beq/bne.
- J-type:
  - 02 j: `id_jump`.
  - 03 jal: `id_jump`, `id_link`, dest 31, `reg_write`.
- Targets:
  - `branch_target = pc_plus4 + (sext(imm)<<2)`, mod 2^32.
  - `jump_target = {pc_plus4[31:28], instr[25:0], 2'b00}`.
- `id_reg_write` is forced to 0 when `id_dest==0`. This makes 0x00000000 a true NOP.
- Unknown op or funct: `id_illegal=1` and all write/mem/branch/jump controls are 0; `id_valid` still follows the handshake.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible on `id_*` after edge N.
- Throughput is 1 instruction per cycle while `ex_ready=1`.
- `if_ready` is combinational from `id_valid` and `ex_ready`.
- Reset:
  - `id_valid=0`, all `id_*` outputs 0, `id_alu_op=0`.
  - All 32 registers are cleared to 0.
  - A reset in mid-stall discards the held instruction.
- Simultaneous events:
  - Priority is reset > flush > accept/hold.
  - A flush during a hold drops the held instruction.
  - A writeback coincident with an accept is seen through the bypass.

## Test plan
- Reset, then `addi $1,$0,5` (0x20010005) with `ex_ready=1`: one cycle later `id_valid=1`, `alu_op=0`, `alu_src=1`, `imm=5`, `dest=1`, `reg_write=1`.
- Write `$2=0xDEADBEEF` via wb while accepting `add $3,$2,$2` in the same cycle: `id_rs_data=id_rt_data=0xDEADBEEF` (bypass).
- `beq` at `pc_plus4=0x100` with imm 0xFFFF: `branch_target=0xFC`, `branch_eq=1`, `reg_write=0`.
- Hold `ex_ready=0` for 3 cycles after `lw $4,8($5)` while wb writes `$5=0x40`: `if_ready=0`; all fields are stable except `rs_data`, which becomes 0x40.
- Instruction 0x00000000: `reg_write=0`, `illegal=0`. Op 0x3F: `illegal=1`, all controls 0.
- `flush` during a hold with `if_valid=1`: `id_valid=0` next cycle and the incoming instruction never appears.
